// File: rtl/control_unit_if.sv
// Datapath-side bus of the control unit: ROM fetch, register file ports and ALU handshake.
interface control_unit_if;
  logic [15:0] pc;
  logic [15:0] instruction;
  logic [2:0]  reg_read_address_1;
  logic [2:0]  reg_read_address_2;
  logic [15:0] reg_read_data_1;
  logic [15:0] reg_read_data_2;
  logic        reg_write_enable;
  logic [2:0]  reg_write_destination;
  logic        wb_sel;
  logic [15:0] imm;
  logic [1:0]  alu_op;
  logic        alu_start;
  logic        alu_done;

  modport master (
    output pc, reg_read_address_1, reg_read_address_2, reg_write_enable,
           reg_write_destination, wb_sel, imm, alu_op, alu_start,
    input  instruction, reg_read_data_1, reg_read_data_2, alu_done
  );

  modport slave (
    input  pc, reg_read_address_1, reg_read_address_2, reg_write_enable,
           reg_write_destination, wb_sel, imm, alu_op, alu_start,
    output instruction, reg_read_data_1, reg_read_data_2, alu_done
  );
endinterface

// File: rtl/control_unit.sv
// Multicycle sequencer: FETCH/DECODE/EXECUTE/WAIT/WRITEBACK over a 16-bit ISA, sticky HALT.
module control_unit #(
  parameter int PROG_WORDS = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run,
  control_unit_if.master bus,
  output logic           halted,
  output logic           fault
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT, S_WB, S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_MUL = 4'h3,
                         OP_LDI = 4'h4, OP_BEQ = 4'h5, OP_HLT = 4'hF;

  state_t      state, state_n;
  logic [15:0] pc_q, pc_n, ir, ir_n;
  logic        fault_n;
  logic [3:0]  op;
  logic        is_alu, in_range, br_eq;
  logic [15:0] pc_inc, br_tgt;

  assign op       = ir[15:12];
  assign is_alu   = (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  assign in_range = {1'b0, pc_q[15:1]} < 16'(PROG_WORDS);
  assign br_eq    = (bus.reg_read_data_1 == bus.reg_read_data_2);
  assign pc_inc   = pc_q + 16'd2;
  // Word offset scaled to bytes; 16-bit wrap is intentional and caught by the fetch range check.
  assign br_tgt   = pc_inc + {{9{ir[5]}}, ir[5:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc_q  <= '0;
      ir    <= '0;
      fault <= 1'b0;
    end else begin
      state <= state_n;
      pc_q  <= pc_n;
      ir    <= ir_n;
      fault <= fault_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    ir_n    = ir;
    fault_n = fault;
    case (state)
      S_IDLE:   if (run) state_n = S_FETCH;
      S_FETCH: begin
        if (!in_range) begin
          state_n = S_HALT;
          fault_n = 1'b1;
        end else begin
          ir_n    = bus.instruction;
          state_n = S_DECODE;
        end
      end
      S_DECODE: state_n = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_NOP: begin
            pc_n    = pc_inc;
            state_n = S_FETCH;
          end
          OP_ADD, OP_SUB, OP_MUL: state_n = S_WAIT;
          OP_LDI: state_n = S_WB;
          OP_BEQ: begin
            pc_n    = br_eq ? br_tgt : pc_inc;
            state_n = S_FETCH;
          end
          OP_HLT: state_n = S_HALT;
          default: begin
            state_n = S_HALT;
            fault_n = 1'b1;
          end
        endcase
      end
      S_WAIT:   if (bus.alu_done) state_n = S_WB;
      S_WB: begin
        pc_n    = pc_inc;
        state_n = S_FETCH;
      end
      S_HALT:   state_n = S_HALT;
      default:  state_n = S_IDLE;
    endcase
  end

  // Decoded outputs come only from ir so they stay stable from DECODE through WRITEBACK.
  always_comb begin
    bus.reg_read_address_1 = 3'd0;
    bus.reg_read_address_2 = 3'd0;
    bus.imm                = 16'd0;
    bus.alu_op             = 2'd0;
    if (is_alu) begin
      bus.reg_read_address_1 = ir[8:6];
      bus.reg_read_address_2 = ir[5:3];
    end else if (op == OP_BEQ) begin
      bus.reg_read_address_1 = ir[11:9];
      bus.reg_read_address_2 = ir[8:6];
    end
    if (op == OP_LDI) bus.imm = {7'd0, ir[8:0]};
    if (op == OP_SUB) bus.alu_op = 2'd1;
    else if (op == OP_MUL) bus.alu_op = 2'd2;
  end

  assign bus.pc                    = pc_q;
  assign bus.reg_write_destination = ir[11:9];
  assign bus.wb_sel                = (op == OP_LDI);
  assign bus.reg_write_enable      = (state == S_WB);
  assign bus.alu_start             = (state == S_EXEC) && is_alu;
  assign halted                    = (state == S_HALT);
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: ROM, register file and ALU models around the sequencer.
module tb_control_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic halted, fault;

  control_unit_if bus();

  control_unit #(.PROG_WORDS(15)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .bus    (bus.master),
    .halted (halted),
    .fault  (fault)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [0:15];
  logic [15:0] rf  [0:7];
  logic [15:0] ld1 = 16'd0, ld2 = 16'd0;
  int          alu_delay = 1;
  int          alu_cnt = 0;
  logic [15:0] alu_res = 16'd0;

  assign bus.instruction     = rom[bus.pc[4:1]];
  assign bus.reg_read_data_1 = rf[bus.reg_read_address_1];
  assign bus.reg_read_data_2 = rf[bus.reg_read_address_2];
  assign bus.alu_done        = (alu_cnt == 0);

  function automatic logic [15:0] alu_f(input logic [1:0] o, input logic [15:0] a, b);
    case (o)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a * b;
      default: return 16'd0;
    endcase
  endfunction

  // Register file preloads while reset is held; ALU answers alu_delay cycles into WAIT.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'd0;
      rf[1]   <= ld1;
      rf[2]   <= ld2;
      alu_cnt <= 0;
    end else begin
      if (bus.reg_write_enable)
        rf[bus.reg_write_destination] <= bus.wb_sel ? bus.imm : alu_res;
      if (bus.alu_start) begin
        alu_res <= alu_f(bus.alu_op, bus.reg_read_data_1, bus.reg_read_data_2);
        alu_cnt <= alu_delay - 1;
      end else if (alu_cnt > 0) begin
        alu_cnt <= alu_cnt - 1;
      end
    end
  end

  int          cyc_ctr = 0, n_start = 0, start_cyc = 0, n_wr = 0, tot_wr = 0;
  logic [1:0]  start_op = 2'd0;
  logic [2:0]  wr_dest [8];
  logic [15:0] wr_data [8];
  logic [15:0] wr_pc   [8];
  logic        wr_sel  [8];
  int          wr_cyc  [8];

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_ctr <= 0;
      n_start <= 0;
      n_wr    <= 0;
    end else begin
      cyc_ctr <= cyc_ctr + 1;
      if (bus.alu_start) begin
        n_start   <= n_start + 1;
        start_cyc <= cyc_ctr;
        start_op  <= bus.alu_op;
      end
      if (bus.reg_write_enable) begin
        tot_wr <= tot_wr + 1;
        n_wr   <= n_wr + 1;
        if (n_wr < 8) begin
          wr_dest[n_wr] <= bus.reg_write_destination;
          wr_data[n_wr] <= bus.wb_sel ? bus.imm : alu_res;
          wr_sel[n_wr]  <= bus.wb_sel;
          wr_pc[n_wr]   <= bus.pc;
          wr_cyc[n_wr]  <= cyc_ctr;
        end
      end
    end
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] outs();
    return {bus.pc, bus.reg_read_address_1, bus.reg_read_address_2, bus.reg_write_enable,
            bus.reg_write_destination, bus.wb_sel, bus.imm, bus.alu_op, bus.alu_start,
            halted, fault};
  endfunction

  task automatic do_reset(input logic [15:0] r1, input logic [15:0] r2, input int dly);
    ld1 = r1; ld2 = r2; alu_delay = dly; run = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic fill_rom(input logic [15:0] w);
    for (int i = 0; i < 16; i++) rom[i] = w;
  endtask

  // Pulse run for one edge only; cyc counts cycles from FETCH entry to HALT entry.
  task automatic run_prog(output int cyc);
    run = 1'b1; cyc = 0;
    @(posedge clk); #1 run = 1'b0;
    while (!halted && cyc < 300) begin
      @(posedge clk); #1 cyc++;
    end
    if (!halted) chk("halt_timeout", 64'(halted), 64'd1);
  endtask

  int cyc, wr_before;

  initial begin
    fill_rom(16'h9000);
    #1 chk("reset_outs", 64'(outs()), 64'd0);

    // LDI r1,5; LDI r2,7; ADD r3,r1,r2; HALT with alu_done always ready.
    fill_rom(16'h9000);
    rom[0] = 16'h4205; rom[1] = 16'h4407; rom[2] = 16'h1650; rom[3] = 16'hF000;
    do_reset(16'd0, 16'd0, 1);
    chk("idle_outs", 64'(outs()), 64'd0);
    run_prog(cyc);
    chk("t1_cycles", 64'(cyc), 64'd16);
    chk("t1_nwr", 64'(n_wr), 64'd3);
    chk("t1_wr0", {wr_dest[0], wr_sel[0], wr_data[0]}, {3'd1, 1'b1, 16'd5});
    chk("t1_wr1", {wr_dest[1], wr_sel[1], wr_data[1]}, {3'd2, 1'b1, 16'd7});
    chk("t1_wr2", {wr_dest[2], wr_sel[2], wr_data[2]}, {3'd3, 1'b0, 16'd12});
    chk("t1_end", {halted, fault, bus.pc}, {1'b1, 1'b0, 16'd6});
    chk("t1_add_op", 64'(start_op), 64'd0);

    // MUL with the result arriving on the 4th WAIT cycle.
    rom[0] = 16'h4203; rom[1] = 16'h4404; rom[2] = 16'h3650; rom[3] = 16'hF000;
    do_reset(16'd0, 16'd0, 4);
    run_prog(cyc);
    chk("t2_nstart", 64'(n_start), 64'd1);
    chk("t2_op", 64'(start_op), 64'd2);
    chk("t2_wait", 64'(wr_cyc[2] - start_cyc - 1), 64'd4);
    chk("t2_nwr", 64'(n_wr), 64'd3);
    chk("t2_wr2", {wr_dest[2], wr_pc[2], wr_data[2]}, {3'd3, 16'd4, 16'd12});
    chk("t2_end", {halted, fault, bus.pc}, {1'b1, 1'b0, 16'd6});
    chk("t2_cycles", 64'(cyc), 64'd19);
    chk("t2_rf3", 64'(rf[3]), 64'd12);

    // BEQ r1,r2,+2 at pc 4: taken lands on HALT at 10, not taken on HALT at 6.
    fill_rom(16'h9000);
    rom[0] = 16'h0000; rom[1] = 16'h0000; rom[2] = 16'h5282; rom[3] = 16'hF000; rom[5] = 16'hF000;
    do_reset(16'd3, 16'd3, 1);
    run_prog(cyc);
    chk("beq_taken", {halted, fault, bus.pc}, {1'b1, 1'b0, 16'd10});
    chk("beq_taken_cyc", 64'(cyc), 64'd12);
    do_reset(16'd3, 16'd4, 1);
    run_prog(cyc);
    chk("beq_not_taken", {halted, fault, bus.pc}, {1'b1, 1'b0, 16'd6});

    // Forward +3 from pc 0 to 8, then -3 from pc 8 back to HALT at 4.
    fill_rom(16'h9000);
    rom[0] = 16'h5283; rom[2] = 16'hF000; rom[4] = 16'h52BD;
    do_reset(16'd3, 16'd3, 1);
    run_prog(cyc);
    chk("beq_back", {halted, fault, bus.pc}, {1'b1, 1'b0, 16'd4});
    chk("beq_back_cyc", 64'(cyc), 64'd9);

    // Illegal opcode at pc 0.
    fill_rom(16'h9000);
    do_reset(16'd0, 16'd0, 1);
    run_prog(cyc);
    chk("illegal", {halted, fault, bus.pc}, {1'b1, 1'b1, 16'd0});
    chk("illegal_nwr", 64'(n_wr), 64'd0);
    chk("illegal_cyc", 64'(cyc), 64'd3);

    // No HALT: 15 NOPs then the fetch at pc 30 faults.
    fill_rom(16'h0000);
    do_reset(16'd0, 16'd0, 1);
    run_prog(cyc);
    chk("runoff", {halted, fault, bus.pc}, {1'b1, 1'b1, 16'd30});
    chk("runoff_cyc", 64'(cyc), 64'd46);

    // Branch -2 from pc 0 wraps to 0xFFFE.
    fill_rom(16'h9000);
    rom[0] = 16'h52BE;
    do_reset(16'd3, 16'd3, 1);
    run_prog(cyc);
    chk("wrap", {halted, fault, bus.pc}, {1'b1, 1'b1, 16'hFFFE});
    chk("wrap_cyc", 64'(cyc), 64'd4);

    // Reset pulled mid-WAIT of a MUL, then rerun from pc 0.
    fill_rom(16'h9000);
    rom[0] = 16'h3650; rom[1] = 16'hF000;
    do_reset(16'd3, 16'd5, 20);
    run = 1'b1;
    for (int i = 0; i < 20 && n_start == 0; i++) @(negedge clk);
    chk("mid_start", 64'(n_start), 64'd1);
    repeat (2) @(negedge clk);
    chk("mid_in_wait", {bus.alu_start, bus.reg_write_enable, halted}, 3'b000);
    wr_before = tot_wr;
    #2 rst_n = 1'b0;
    #1 chk("mid_async_outs", 64'(outs()), 64'd0);
    repeat (3) @(posedge clk);
    #1 chk("mid_no_wb", 64'(tot_wr), 64'(wr_before));
    alu_delay = 1;
    @(negedge clk) rst_n = 1'b1;
    run_prog(cyc);
    chk("restart_nwr", 64'(n_wr), 64'd1);
    chk("restart_wr", {wr_pc[0], wr_dest[0], wr_data[0]}, {16'd0, 3'd3, 16'd15});
    chk("restart_end", {halted, fault, bus.pc}, {1'b1, 1'b0, 16'd2});
    chk("restart_cyc", 64'(cyc), 64'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/control_unit.md
# control_unit

Multicycle sequencer for the 16-bit CPU datapath. Owns the program counter, fetches 16-bit words from the instruction ROM, drives the 8×16 register file's read and write ports, and handshakes with the shared ALU/multiplier. It retires one instruction at a time through FETCH/DECODE/EXECUTE/WAIT/WRITEBACK and stops in a sticky HALT state.

## Interface
Parameters:
- PROG_WORDS, default 15: number of valid ROM words. Valid byte PCs are 0 … 2·(PROG_WORDS−1).

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- run  in  1  leave IDLE and start execution (level, sampled in IDLE)
- instruction  in  16  ROM word addressed by pc; combinational from pc
- reg_read_data_1  in  16  register file read port 1 data
- reg_read_data_2  in  16  register file read port 2 data
- alu_done  in  1  ALU result valid; held until the next alu_start
- pc  out  16  byte program counter, always even
- reg_read_address_1  out  3  read port 1 index
- reg_read_address_2  out  3  read port 2 index
- reg_write_enable  out  1  one-cycle register write strobe
- reg_write_destination  out  3  write index
- wb_sel  out  1  write-data mux select: 0 = ALU result, 1 = imm
- imm  out  16  decoded immediate
- alu_op  out  2  0 ADD, 1 SUB, 2 MUL, 3 reserved
- alu_start  out  1  one-cycle ALU launch pulse
- halted  out  1  core is in HALT
- fault  out  1  halt cause: illegal opcode or PC out of range

## Operation
- Instruction register `ir` (16 bits) captures `instruction` in FETCH. Every decoded output derives from `ir`, never from `instruction` directly.
- Encoding, op = ir[15:12]:
  - 0x0 NOP.
  - 0x1 ADD, 0x2 SUB, 0x3 MUL: rd = ir[11:9], rs1 = ir[8:6], rs2 = ir[5:3]; ir[2:0] ignored.
  - 0x4 LDI: rd = ir[11:9], imm = zero-extended ir[8:0].
  - 0x5 BEQ: rs1 = ir[11:9], rs2 = ir[8:6], off = signed ir[5:0] in words.
  - 0xF HALT.
  - All other opcodes are illegal.
- States:
  - IDLE: wait for run = 1, then go to FETCH.
  - FETCH: if pc[15:1] ≥ PROG_WORDS, go to HALT with fault = 1. Otherwise load ir and go to DECODE.
  - DECODE: drive the read addresses from ir, then go to EXECUTE.
  - EXECUTE:
    - ADD/SUB/MUL: alu_start = 1 for this cycle with alu_op set, then go to WAIT.
    - LDI: go to WRITEBACK.
    - NOP: pc += 2, then go to FETCH.
    - BEQ: if reg_read_data_1 == reg_read_data_2, pc = pc + 2 + (sext(off) << 1); else pc += 2. Then go to FETCH.
    - HALT opcode: go to HALT with fault = 0.
    - Illegal opcode: go to HALT with fault = 1.
  - WAIT: hold alu_op. Stay until alu_done = 1, then go to WRITEBACK. alu_done is ignored in every other state.
  - WRITEBACK: reg_write_enable = 1 for exactly this cycle, pc += 2, then go to FETCH.
  - HALT: absorbing. halted = 1; only reset exits.
- pc arithmetic is 16-bit modulo: a backward branch from 0 wraps to 0xFFxx, which the FETCH range check then faults.
- reg_write_destination = ir[11:9] and wb_sel = (op == LDI), valid whenever reg_write_enable = 1.
- Read addresses stay stable from DECODE through EXECUTE for the same instruction.
- Register r0 is an ordinary writable register.

## Timing
- Reset values: state IDLE, pc 0, ir 0, and every output 0, including halted and fault. Reset takes effect immediately and asynchronously. Asserting rst_n low mid-instruction drops alu_start and reg_write_enable in the same cycle, and no partial writeback occurs.
- Cycles per instruction, counted from FETCH entry:
  - NOP, BEQ: 3.
  - LDI: 4.
  - ADD/SUB/MUL: 4 + W, where W ≥ 1 is the number of WAIT cycles. If alu_done is already high on the first WAIT cycle, W = 1 and the total is 5.
- alu_start is high for exactly one cycle per ALU instruction and never while in WAIT.
- run is ignored outside IDLE. Deasserting run mid-program has no effect.
- halted and fault assert on the first cycle in HALT and stay set until reset.

## Test plan
- Reset then run: program LDI r1,5; LDI r2,7; ADD r3,r1,r2; HALT, with alu_done tied high and a model returning 12. Expect writes r1 = 5 (wb_sel 1), r2 = 7, r3 = 12 (wb_sel 0), then halted = 1, fault = 0, pc = 6, total 4+4+5+3 cycles.
- MUL with alu_done delayed 4 cycles: expect alu_start to pulse once with alu_op = 2, 4 WAIT cycles, reg_write_enable to pulse once, and pc to advance by 2 only after writeback.
- Branches with r1 = r2 = 3:
  - BEQ r1,r2,+2 at pc 4: pc becomes 10.
  - With r2 = 4: pc becomes 6.
  - BEQ off = −3 at pc 8: pc becomes 4.
- Faults:
  - Opcode 0x9 at pc 0 gives halted = 1, fault = 1, and no register write.
  - A program without HALT runs off word 14 into pc 30 and faults.
  - A branch to pc 0xFFFE faults.
- Reset mid-WAIT during a MUL: pull rst_n low. Expect all outputs 0 asynchronously and no writeback. After release with run = 1, execution restarts at pc 0.
